// File: rtl/rc4_encrypt_memory.sv
`default_nettype none
// ============================================================================
// Module      : rc4_encrypt_memory
// Description : RC4 encryptor. It initialises the S table, runs the key
//               schedule with a 24-bit key, then generates keystream bytes.
//               Each keystream byte is XORed with a plaintext ROM byte and
//               the result is written into a ciphertext RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_encrypt_memory #(
    parameter int MSG_LEN = 32,
    parameter int KEY_LEN = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_flag,
    output logic        done_flag,
    input  logic [23:0] secret_key,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_data_in,
    input  logic [7:0]  s_data_out,
    output logic        s_wren,
    output logic [7:0]  p_addr,
    input  logic [7:0]  p_data_out,
    output logic [7:0]  c_addr,
    output logic [7:0]  c_data_in,
    output logic        c_wren
);

    localparam logic [7:0] c_last_k       = 8'(MSG_LEN - 1);
    localparam logic [1:0] c_last_key_idx = 2'(KEY_LEN - 1);

    // RD_I..WR_J are shared between the key schedule and keystream
    // generation; r_prga tells the two apart.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INIT   = 4'd1,
        ST_RD_I   = 4'd2,
        ST_WAIT_I = 4'd3,
        ST_RD_J   = 4'd4,
        ST_WAIT_J = 4'd5,
        ST_WR_I   = 4'd6,
        ST_WR_J   = 4'd7,
        ST_RD_F   = 4'd8,
        ST_WAIT_F = 4'd9,
        ST_WR_C   = 4'd10,
        ST_DONE   = 4'd11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_i;
    logic [7:0]  r_j;
    logic [7:0]  r_k;
    logic [7:0]  r_si;
    logic [7:0]  r_sj;
    logic [7:0]  r_f;
    logic [7:0]  r_p;
    logic [23:0] r_key;
    logic [1:0]  r_key_idx;
    logic        r_prga;
    logic [7:0]  w_key_byte;
    logic [7:0]  w_j_add;

    // Key byte for the current KSA iteration (i mod 3, tracked by a counter)
    always_comb begin
        w_key_byte = r_key[7:0];
        case (r_key_idx)
            2'd0:    w_key_byte = r_key[23:16];
            2'd1:    w_key_byte = r_key[15:8];
            default: w_key_byte = r_key[7:0];
        endcase
        w_j_add = r_prga ? 8'd0 : w_key_byte;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and memory port drive
    always_comb begin
        w_next    = r_state;
        done_flag = 1'b0;
        s_addr    = 8'd0;
        s_data_in = 8'd0;
        s_wren    = 1'b0;
        p_addr    = 8'd0;
        c_addr    = 8'd0;
        c_data_in = 8'd0;
        c_wren    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_flag) w_next = ST_INIT;
            end
            ST_INIT: begin
                s_addr    = r_i;
                s_data_in = r_i;
                s_wren    = 1'b1;
                if (r_i == 8'hFF) w_next = ST_RD_I;
            end
            ST_RD_I: begin
                s_addr = r_prga ? (r_i + 8'd1) : r_i;
                w_next = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                s_addr = r_i;
                w_next = ST_RD_J;
            end
            ST_RD_J: begin
                s_addr = r_j;
                w_next = ST_WAIT_J;
            end
            ST_WAIT_J: begin
                s_addr = r_j;
                w_next = ST_WR_I;
            end
            ST_WR_I: begin
                s_addr    = r_i;
                s_data_in = r_sj;
                s_wren    = 1'b1;
                w_next    = ST_WR_J;
            end
            ST_WR_J: begin
                s_addr    = r_j;
                s_data_in = r_si;
                s_wren    = 1'b1;
                w_next    = r_prga ? ST_RD_F : ST_RD_I;
            end
            ST_RD_F: begin
                s_addr = r_si + r_sj;
                p_addr = r_k;
                w_next = ST_WAIT_F;
            end
            ST_WAIT_F: begin
                s_addr = r_si + r_sj;
                p_addr = r_k;
                w_next = ST_WR_C;
            end
            ST_WR_C: begin
                c_addr    = r_k;
                c_data_in = r_f ^ r_p;
                c_wren    = 1'b1;
                w_next    = (r_k == c_last_k) ? ST_DONE : ST_RD_I;
            end
            ST_DONE: begin
                done_flag = 1'b1;
                if (!start_flag) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Index, key and temporary registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i       <= 8'd0;
            r_j       <= 8'd0;
            r_k       <= 8'd0;
            r_si      <= 8'd0;
            r_sj      <= 8'd0;
            r_f       <= 8'd0;
            r_p       <= 8'd0;
            r_key     <= 24'd0;
            r_key_idx <= 2'd0;
            r_prga    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_flag) begin
                        r_key     <= secret_key;
                        r_i       <= 8'd0;
                        r_j       <= 8'd0;
                        r_k       <= 8'd0;
                        r_key_idx <= 2'd0;
                        r_prga    <= 1'b0;
                    end
                end
                ST_INIT: begin
                    // i wraps 255 -> 0, ready for the key schedule
                    r_i <= r_i + 8'd1;
                    r_j <= 8'd0;
                end
                ST_RD_I: begin
                    if (r_prga) r_i <= r_i + 8'd1;
                end
                ST_WAIT_I: begin
                    r_si <= s_data_out;
                    r_j  <= r_j + s_data_out + w_j_add;
                end
                ST_WAIT_J: begin
                    r_sj <= s_data_out;
                end
                ST_WR_J: begin
                    if (!r_prga) begin
                        r_i       <= r_i + 8'd1;
                        r_key_idx <= (r_key_idx == c_last_key_idx) ? 2'd0 : r_key_idx + 2'd1;
                        if (r_i == 8'hFF) begin
                            r_j    <= 8'd0;
                            r_k    <= 8'd0;
                            r_prga <= 1'b1;
                        end
                    end
                end
                ST_WAIT_F: begin
                    r_f <= s_data_out;
                    r_p <= p_data_out;
                end
                ST_WR_C: begin
                    r_k <= r_k + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_encrypt_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_encrypt_memory
// Description : Scoreboard bench for rc4_encrypt_memory with S RAM, plaintext
//               ROM and ciphertext RAM models (one-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_encrypt_memory;

    localparam int N = 9;
    localparam int LAT = 1792 + 9 * N;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_flag = 1'b0;
    logic [23:0] secret_key = 24'd0;
    logic        done_flag;
    logic [7:0]  s_addr, s_data_in, s_data_out;
    logic        s_wren;
    logic [7:0]  p_addr, p_data_out;
    logic [7:0]  c_addr, c_data_in;
    logic        c_wren;

    logic [7:0]  s_mem [256];
    logic [7:0]  p_rom [256];
    logic [7:0]  c_mem [256];
    logic [15:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    logic [7:0] plain_txt [N] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] key_vec   [N] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] orig [N];

    rc4_encrypt_memory #(.MSG_LEN(N), .KEY_LEN(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_flag (start_flag),
        .done_flag  (done_flag),
        .secret_key (secret_key),
        .s_addr     (s_addr),
        .s_data_in  (s_data_in),
        .s_data_out (s_data_out),
        .s_wren     (s_wren),
        .p_addr     (p_addr),
        .p_data_out (p_data_out),
        .c_addr     (c_addr),
        .c_data_in  (c_data_in),
        .c_wren     (c_wren)
    );

    always #5 clk = ~clk;

    // Synchronous memories: read data valid the cycle after the address
    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_data_in;
        if (c_wren) c_mem[c_addr] <= c_data_in;
        s_data_out <= s_mem[s_addr];
        p_data_out <= p_rom[p_addr];
    end

    // Monitor: every ciphertext write is popped against the scoreboard
    always @(negedge clk) begin
        if (reset_n && c_wren) begin
            checks++;
            if (s_wren) begin
                errors++;
                $display("FAIL wren_overlap s_wren=%0b required 0", s_wren);
            end
            checks++;
            if (c_addr > 8'(N - 1)) begin
                errors++;
                $display("FAIL c_addr_range got %0d required <= %0d", c_addr, N - 1);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cwrite addr=%0d data=%02h required no write", c_addr, c_data_in);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if ({c_addr, c_data_in} !== e) begin
                    errors++;
                    $display("FAIL cipher_byte got addr=%0d data=%02h required addr=%0d data=%02h",
                             c_addr, c_data_in, e[15:8], e[7:0]);
                end
            end
        end
    end

    // Reference RC4 over the current plaintext ROM; pushes expected writes
    function automatic void push_model(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] ii, jj, t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        jj = 8'd0;
        for (int x = 0; x < 256; x++) begin
            jj    = jj + s[x] + kb[x % 3];
            t     = s[x];
            s[x]  = s[jj];
            s[jj] = t;
        end
        ii = 8'd0;
        jj = 8'd0;
        for (int k = 0; k < N; k++) begin
            ii    = ii + 8'd1;
            jj    = jj + s[ii];
            t     = s[ii];
            s[ii] = s[jj];
            s[jj] = t;
            t     = s[ii] + s[jj];
            sb.push_back({8'(k), s[t] ^ p_rom[k]});
        end
    endfunction

    task automatic push_list(input logic [7:0] d [N]);
        for (int k = 0; k < N; k++) sb.push_back({8'(k), d[k]});
    endtask

    // Start a run, optionally snoop S after INIT or swap the key mid-run,
    // then wait for done and check latency and scoreboard drain
    task automatic run(input logic [23:0] key, input bit snoop, input int toggle_at,
                       input logic [23:0] alt_key);
        int n;
        int bad;
        @(negedge clk);
        secret_key = key;
        start_flag = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == toggle_at) secret_key = alt_key;
            if (snoop && n == 256) begin
                bad = 0;
                for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL init_snoop got %0d wrong entries required 0", bad);
                end
            end
            if (done_flag) break;
        end
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL done_latency got %0d edges required %0d", n, LAT);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start_flag = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done_flag !== 1'b0) begin
            errors++;
            $display("FAIL done_clears got %0b required 0", done_flag);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({done_flag, s_wren, c_wren, s_addr, s_data_in, p_addr, c_addr, c_data_in} !== '0) begin
            errors++;
            $display("FAIL %s got done=%0b sw=%0b cw=%0b sa=%02h sd=%02h pa=%02h ca=%02h cd=%02h required all 0",
                     name, done_flag, s_wren, c_wren, s_addr, s_data_in, p_addr, c_addr, c_data_in);
        end
    endtask

    initial begin
        int cnt;
        for (int x = 0; x < 256; x++) begin
            s_mem[x] = 8'(x) ^ 8'h5A;
            p_rom[x] = 8'h00;
            c_mem[x] = 8'h00;
        end
        for (int k = 0; k < N; k++) p_rom[k] = plain_txt[k];

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        // Abort INIT at cycle 100 with the asynchronous reset
        @(negedge clk);
        secret_key = 24'h4B6579;
        start_flag = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b0;
        start_flag = 1'b0;
        #1;
        check_idle_outputs("reset_mid_init");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Restart with key 0; S must be the identity after INIT
        push_model(24'h000000);
        run(24'h000000, 1'b1, 0, 24'd0);
        drop_start();

        // Published "Key"/"Plaintext" vector
        push_list(key_vec);
        run(24'h4B6579, 1'b0, 0, 24'd0);

        // Hold start through DONE: done stays high, no further writes
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_flag) cnt++;
        end
        checks++;
        if (cnt != 20) begin
            errors++;
            $display("FAIL done_hold got %0d cycles required 20", cnt);
        end
        drop_start();
        push_list(key_vec);
        run(24'h4B6579, 1'b0, 0, 24'd0);
        drop_start();

        // Round trip: encrypt random plaintext, then encrypt the ciphertext
        for (int k = 0; k < N; k++) begin
            orig[k]  = 8'($urandom_range(0, 255));
            p_rom[k] = orig[k];
        end
        push_model(24'h000249);
        run(24'h000249, 1'b0, 0, 24'd0);
        drop_start();
        for (int k = 0; k < N; k++) p_rom[k] = c_mem[k];
        push_list(orig);
        run(24'h000249, 1'b0, 0, 24'd0);
        drop_start();

        // Key boundary
        for (int k = 0; k < N; k++) p_rom[k] = plain_txt[k];
        push_model(24'h3FFFFF);
        run(24'h3FFFFF, 1'b0, 0, 24'd0);
        drop_start();

        // Key changed during KSA must be ignored
        push_model(24'h123456);
        run(24'h123456, 1'b0, 400, 24'hFFFFFF);
        drop_start();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
